// File: rtl/arf096b256e1r1w0cbbeheaa4acw_msff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arf096b256e1r1w0cbbeheaa4acw_msff_pkg: shared pipe constants/helpers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arf096b256e1r1w0cbbeheaa4acw_msff_pkg;

  localparam int DEF_DWIDTH = 1;
  localparam int DEF_DEPTH  = 2;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arf096b256e1r1w0cbbeheaa4acw_msff_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arf096b256e1r1w0cbbeheaa4acw_msff_stage: one valid+payload pipe stage |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arf096b256e1r1w0cbbeheaa4acw_msff_stage
  import arf096b256e1r1w0cbbeheaa4acw_msff_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              src_valid,
  input  logic [DWIDTH-1:0] src_data,
  output logic              valid,
  output logic [DWIDTH-1:0] data
);

  // Payload only moves when a real item arrives, so bubbles never toggle data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (en) begin
        valid <= src_valid;
      end
      if (en && src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arf096b256e1r1w0cbbeheaa4acw_msff_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arf096b256e1r1w0cbbeheaa4acw_msff_pipe: bubble-collapsing valid pipe  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arf096b256e1r1w0cbbeheaa4acw_msff_pipe
  import arf096b256e1r1w0cbbeheaa4acw_msff_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DWIDTH-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  acc;
  logic [DEPTH-1:0]  src_v;
  logic [DEPTH-1:0]  v_next;
  logic [DWIDTH-1:0] d     [DEPTH];
  logic [DWIDTH-1:0] src_d [DEPTH];
  logic [CW-1:0]     cnt_next;

  // A stage can take new content if it is empty or everything after it moves.
  always_comb begin
    acc = '0;
    acc[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc[i] = ~v[i] | acc[i+1];
    end
  end

  assign in_ready = acc[0] & ~flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign src_v[i] = in_valid & in_ready;
      assign src_d[i] = in_data;
    end else begin : g_next
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end

    arf096b256e1r1w0cbbeheaa4acw_msff_stage #(
      .DWIDTH (DWIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (acc[i]),
      .clr       (flush),
      .src_valid (src_v[i]),
      .src_data  (src_d[i]),
      .valid     (v[i]),
      .data      (d[i])
    );
  end

  // Occupancy is tracked from the same next-state the stages will load.
  always_comb begin
    v_next   = flush ? '0 : ((acc & src_v) | (~acc & v));
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= cnt_next;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule
`default_nettype wire
